// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - timed multiply/divide sequencer owning HI/LO for the E stage
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,      // asynchronous, active-low
  input  logic        start_i,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        int_req_i,
  input  logic [3:0]  ao_s_i,
  input  logic        d_mdu_use_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] rd_data_o
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic               pend_we_q;

  logic               go, commit, wr_hi, wr_lo;
  logic [63:0]        prod_u, prod_s;
  logic               signed_div, neg_q, neg_r, is_div;
  logic [31:0]        abs_a, abs_b, quo_mag, rem_mag;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;
  logic [CNT_W-1:0]   cnt_init;

  // A flushed or mid-operation start never issues.
  assign go = start_i & ~int_req_i & (state_q == IDLE);

  // Result computed at issue time; the busy window only models latency.
  always_comb begin
    prod_u     = {32'd0, src_a_i} * {32'd0, src_b_i};
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s     = {{32{src_a_i[31]}}, src_a_i} * {{32{src_b_i[31]}}, src_b_i};
    signed_div = (mdu_op_i == OP_DIV);
    is_div     = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
    abs_a      = (signed_div && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
    abs_b      = (signed_div && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;
    // Guard the divider against /0; the result is discarded in that case anyway.
    if (abs_b == 32'd0) abs_b = 32'd1;
    quo_mag    = abs_a / abs_b;
    rem_mag    = abs_a % abs_b;
    // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 rem 0 naturally.
    neg_q      = signed_div & (src_a_i[31] ^ src_b_i[31]);
    neg_r      = signed_div & src_a_i[31];
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_we     = 1'b0;
    case (mdu_op_i)
      OP_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
      OP_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
      OP_DIVU, OP_DIV: begin
        res_lo = neg_q ? (~quo_mag + 32'd1) : quo_mag;
        res_hi = neg_r ? (~rem_mag + 32'd1) : rem_mag;
        res_we = (src_b_i != 32'd0);
      end
      default: ;
    endcase
    cnt_init = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: leave BUSY on the edge that follows the last counted cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag, commit strobe and idle-only HI/LO moves.
  always_comb begin
    busy_o = (state_q == BUSY);
    commit = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    wr_hi  = (state_q == IDLE) && !int_req_i && (mdu_op_i == OP_MTHI);
    wr_lo  = (state_q == IDLE) && !int_req_i && (mdu_op_i == OP_MTLO);
  end

  // Datapath registers: pending result, cycle counter and architectural HI/LO.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      if (go) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        pend_we_q <= res_we;
        cnt_q     <= cnt_init;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit && pend_we_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
      if (wr_hi) hi_q <= src_a_i;
      if (wr_lo) lo_q <= src_a_i;
    end
  end

  // Stall on raw start so a flushed issue still holds D for its one cycle.
  assign stall_o   = d_mdu_use_i & (busy_o | start_i);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign rd_data_o = (ao_s_i == 4'd1) ? lo_q : (ao_s_i == 4'd2) ? hi_q : 32'd0;

endmodule
